decode_queue: RTL
=================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-002 Parameter PC_W, default 32, width of carried PC.
REQ-003 Parameter INV_W, default 8, width of the invalid-instruction counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  discard all queued entries (exception/branch redirect).
REQ-007 in_valid  input  1  fetch presents an instruction.
REQ-008 in_ready  output  1  queue can accept this cycle.
REQ-009 in_instr  input  32  raw MIPS instruction word.
REQ-010 in_pc  input  PC_W  PC of in_instr.
REQ-011 out_valid  output  1  head entry valid.
REQ-012 out_ready  input  1  execute stage consumes head.
REQ-013 out_instr  output  32  head instruction word.
REQ-014 out_pc  output  PC_W  head PC.
REQ-015 out_ctrl  output  20  head control word, MSB first: regwrite, regdst, alusrc, branch, memtoreg, jump, jal, jr, bal, jalr, aluop[3:0], memen, hilo_we[1:0], invalid, cp0_we, cp0_re.
REQ-016 count  output  clog2(DEPTH)+1  current occupancy.
REQ-017 inv_cnt  output  INV_W  saturating count of accepted invalid instructions.

Function
REQ-018 Decode SHALL be performed at enqueue; the 20-bit control word is stored with instr and pc, never recomputed at dequeue.
REQ-019 Decode SHALL cover the codebase instruction set: I-type logic/arith, J/JAL, BEQ/BNE/BGTZ/BLEZ, REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL, loads/stores, MTC0/MFC0/ERET, R-type logic/shift/HI-LO moves/arith/mult-div/JR/JALR/SYSCALL/BREAK, using aluop encodings from defines2.vh.
REQ-020 Any unlisted op, REGIMM rt, COP0 rs or R-type funct SHALL yield invalid=1 with all other fields 0.
REQ-021 cp0_we=1 only for MTC0; cp0_re=1 only for MFC0; both 0 otherwise.
REQ-022 in_ready = (count < DEPTH), driven from registered state only; no combinational path from out_ready.
REQ-023 Push occurs when in_valid & in_ready & ~flush; pop occurs when out_valid & out_ready & ~flush.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and update both pointers.
REQ-025 Latency: an instruction accepted at edge N appears at head (out_valid=1) after edge N when queue was empty; no combinational bypass.
REQ-026 out_valid = (count != 0); when out_valid=0, out_ctrl, out_instr and out_pc SHALL be 0.
REQ-027 Read/write pointers wrap modulo DEPTH; order SHALL be strictly FIFO.
REQ-028 flush SHALL, at the next edge, set count and both pointers to 0 and override any same-cycle push or pop; inv_cnt unaffected.
REQ-029 inv_cnt increments by 1 on each push whose decoded invalid=1; saturates at 2^INV_W-1; flush does not clear it.
REQ-030 Pushes while full are impossible (in_ready=0); in_valid while full SHALL be held by the producer, not dropped silently by the queue.

Reset
REQ-031 On rst asserted: count=0, pointers=0, inv_cnt=0, out_valid=0, in_ready=1, all data outputs 0, immediately and independent of clk.
REQ-032 rst asserted mid-operation SHALL discard all entries; first accept after deassertion behaves as from empty.
REQ-033 Storage array contents need not be reset; outputs are gated per REQ-026.

Structure
REQ-034 Control-word field positions, width 20, and aluop constants SHALL live in the shared defines header alongside existing opcode/funct defines.
REQ-035 Decode logic SHALL be one combinational sub-module, ctrl_decode (instr in, 20-bit control out); queue storage and counters in decode_queue.

Verification
REQ-036 Reset, push 0x34020005 (ORI) -> next cycle out_valid=1, out_ctrl regwrite=1, alusrc=1, regdst=0, aluop=ORI_OP, invalid=0, count=1.
REQ-037 Push 0x00431021 (ADDU) then 0x40826000 (MTC0) with out_ready=0 -> count=2; then out_ready=1 -> ADDU (regwrite=1, regdst=1) then MTC0 (cp0_we=1, regwrite=0) in order.
REQ-038 Push 0xFC000000 -> out_ctrl = 20'h00004 (invalid only), inv_cnt=1; 300 such pushes with INV_W=8 -> inv_cnt=255.
REQ-039 Fill DEPTH=4 entries -> in_ready=0, count=4; push+pop each cycle thereafter from count=3 -> count stays 3 across pointer wrap, FIFO order preserved.
REQ-040 count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_ctrl=0, inv_cnt unchanged.

Source files
------------

// File: rtl/decode_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : decode_queue_pkg
// Brief  : Shared defines for the decode queue: MIPS opcode/funct codes,
//          control-word layout and ALU operation encodings.
// Rev    : 1.0  initial release
// ============================================================================
package decode_queue_pkg;

  // Control word, MSB first. Bit positions are kept alongside the struct so
  // consumers that slice the raw vector stay in step with the layout.
  localparam int CTRL_W         = 20;
  localparam int CTRL_REGWRITE  = 19;
  localparam int CTRL_REGDST    = 18;
  localparam int CTRL_ALUSRC    = 17;
  localparam int CTRL_BRANCH    = 16;
  localparam int CTRL_MEMTOREG  = 15;
  localparam int CTRL_JUMP      = 14;
  localparam int CTRL_JAL       = 13;
  localparam int CTRL_JR        = 12;
  localparam int CTRL_BAL       = 11;
  localparam int CTRL_JALR      = 10;
  localparam int CTRL_ALUOP_MSB = 9;
  localparam int CTRL_ALUOP_LSB = 6;
  localparam int CTRL_MEMEN     = 5;
  localparam int CTRL_HILO_MSB  = 4;
  localparam int CTRL_HILO_LSB  = 3;
  localparam int CTRL_INVALID   = 2;
  localparam int CTRL_CP0_WE    = 1;
  localparam int CTRL_CP0_RE    = 0;

  typedef struct packed {
    logic       regwrite;
    logic       regdst;
    logic       alusrc;
    logic       branch;
    logic       memtoreg;
    logic       jump;
    logic       jal;
    logic       jr;
    logic       bal;
    logic       jalr;
    logic [3:0] aluop;
    logic       memen;
    logic [1:0] hilo_we;
    logic       invalid;
    logic       cp0_we;
    logic       cp0_re;
  } ctrl_t;

  // ALU operation classes handed to the execute stage
  localparam logic [3:0] NONE_OP  = 4'd0;
  localparam logic [3:0] ADDI_OP  = 4'd1;
  localparam logic [3:0] ADDIU_OP = 4'd2;
  localparam logic [3:0] SLTI_OP  = 4'd3;
  localparam logic [3:0] SLTIU_OP = 4'd4;
  localparam logic [3:0] ANDI_OP  = 4'd5;
  localparam logic [3:0] ORI_OP   = 4'd6;
  localparam logic [3:0] XORI_OP  = 4'd7;
  localparam logic [3:0] LUI_OP   = 4'd8;
  localparam logic [3:0] MEM_OP   = 4'd9;
  localparam logic [3:0] R_OP     = 4'd10;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F, OP_COP0   = 6'h10;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR   = 6'h08, F_JALR = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0C, F_BREAK = 6'h0D;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B, F_ERET = 6'h18;

  // REGIMM rt and COP0 rs selectors
  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
  localparam logic [4:0] RS_MF = 5'h00, RS_MT = 5'h04, RS_CO = 5'h10;

endpackage
`default_nettype wire

// File: rtl/decode_queue_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module : ctrl_decode
// Brief  : Purely combinational MIPS main decoder producing the 20-bit
//          control word; anything unrecognised decodes to invalid-only.
// Rev    : 1.0  initial release
// ============================================================================
module ctrl_decode
  import decode_queue_pkg::*;
(
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       unused_imm;
  ctrl_t      c;

  assign op         = instr[31:26];
  assign rs         = instr[25:21];
  assign rt         = instr[20:16];
  assign funct      = instr[5:0];
  assign unused_imm = ^instr[15:6];
  assign ctrl       = c;

  // Decode the instruction into its control fields
  always_comb begin
    c = '0;
    case (op)
      OP_SPECIAL: begin
        c.aluop = R_OP;
        case (funct)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_MFHI, F_MFLO,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU:                  begin c.regwrite = 1'b1; c.regdst = 1'b1; end
          F_MTHI:                          c.hilo_we = 2'b10;
          F_MTLO:                          c.hilo_we = 2'b01;
          F_MULT, F_MULTU, F_DIV, F_DIVU: c.hilo_we = 2'b11;
          F_JR:                            c.jr = 1'b1;
          F_JALR: begin c.jalr = 1'b1; c.regwrite = 1'b1; c.regdst = 1'b1; end
          F_SYSCALL, F_BREAK: ;
          default: begin c = '0; c.invalid = 1'b1; end
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ:     c.branch = 1'b1;
          RT_BLTZAL, RT_BGEZAL: begin c.branch = 1'b1; c.bal = 1'b1; c.regwrite = 1'b1; end
          default:              c.invalid = 1'b1;
        endcase
      end
      OP_J:   c.jump = 1'b1;
      OP_JAL: begin c.jump = 1'b1; c.jal = 1'b1; c.regwrite = 1'b1; end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: c.branch = 1'b1;
      OP_ADDI:  begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ADDI_OP;  end
      OP_ADDIU: begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ADDIU_OP; end
      OP_SLTI:  begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = SLTI_OP;  end
      OP_SLTIU: begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = SLTIU_OP; end
      OP_ANDI:  begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ANDI_OP;  end
      OP_ORI:   begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ORI_OP;   end
      OP_XORI:  begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = XORI_OP;  end
      OP_LUI:   begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = LUI_OP;   end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        c.regwrite = 1'b1; c.alusrc = 1'b1; c.memtoreg = 1'b1;
        c.memen    = 1'b1; c.aluop  = MEM_OP;
      end
      OP_SB, OP_SH, OP_SW: begin c.alusrc = 1'b1; c.memen = 1'b1; c.aluop = MEM_OP; end
      OP_COP0: begin
        case (rs)
          RS_MT:   c.cp0_we = 1'b1;
          RS_MF:   begin c.regwrite = 1'b1; c.cp0_re = 1'b1; end
          RS_CO:   c.invalid = (funct != F_ERET);  // ERET is the only CO op supported
          default: c.invalid = 1'b1;
        endcase
      end
      default: c.invalid = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module : decode_queue
// Brief  : FIFO between fetch and execute that decodes on enqueue and
//          carries instr, pc and control word together; counts invalids.
// Rev    : 1.0  initial release
// ============================================================================
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int INV_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [PC_W-1:0]          out_pc,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [$clog2(DEPTH):0]   count,
  output logic [INV_W-1:0]         inv_cnt
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]       instr_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem    [DEPTH];
  logic [CTRL_W-1:0] ctrl_mem  [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [INV_W-1:0]  inv_cnt_q, inv_cnt_d;
  logic [CTRL_W-1:0] in_ctrl;
  logic              push, pop;

  ctrl_decode u_ctrl_decode (
    .instr (in_instr),
    .ctrl  (in_ctrl)
  );

  // Handshake is a function of registered occupancy only
  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Empty queue presents all-zero data regardless of stale storage
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;
  assign out_ctrl  = out_valid ? ctrl_mem[rd_ptr_q]  : '0;
  assign count     = count_q;
  assign inv_cnt   = inv_cnt_q;

  // Next pointers, occupancy and saturating invalid counter
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    inv_cnt_d = inv_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
    if (push && in_ctrl[CTRL_INVALID] && (inv_cnt_q != '1))
      inv_cnt_d = inv_cnt_q + 1'b1;
  end

  // Queue state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      inv_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      inv_cnt_q <= inv_cnt_d;
    end
  end

  // Entry storage; unwritten slots are never visible so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= in_instr;
      pc_mem[wr_ptr_q]    <= in_pc;
      ctrl_mem[wr_ptr_q]  <= in_ctrl;
    end
  end

endmodule
`default_nettype wire
